// File: rtl/game_sequencer.sv
// Flappy-style game sequencer: IDLE/PLAY/OVER_HOLD/OVER_WAIT control, pipe and gravity
// tick generation, BCD score with saturation, level progression and persistent best score.
module game_sequencer #(
    parameter int unsigned PIPE_PERIOD_INIT = 8,
    parameter int unsigned PIPE_PERIOD_MIN  = 3,
    parameter int unsigned FALL_PERIOD      = 4,
    parameter int unsigned POINTS_PER_LEVEL = 5,
    parameter int unsigned OVER_HOLD        = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        press,
    input  logic        crash,
    input  logic        point,
    output logic        active,
    output logic        game_over,
    output logic        pipe_tick,
    output logic        fall_tick,
    output logic        flap,
    output logic [11:0] score,
    output logic [11:0] best,
    output logic [3:0]  level
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_PLAY      = 2'd1,
        S_OVER_HOLD = 2'd2,
        S_OVER_WAIT = 2'd3
    } state_t;

    localparam logic [7:0]  INIT8   = 8'(PIPE_PERIOD_INIT);
    localparam logic [7:0]  MIN8    = 8'(PIPE_PERIOD_MIN);
    localparam logic [7:0]  FALL_M1 = 8'(FALL_PERIOD - 1);
    localparam logic [7:0]  PPL_M1  = 8'(POINTS_PER_LEVEL - 1);
    localparam logic [15:0] HOLD_M1 = 16'(OVER_HOLD - 1);

    state_t      state_q;
    logic        active_q;
    logic        game_over_q;
    logic        pipe_tick_q;
    logic        fall_tick_q;
    logic [11:0] score_q;
    logic [11:0] best_q;
    logic [3:0]  level_q;
    logic [7:0]  pt_cnt_q;
    logic [7:0]  pipe_cnt_q;
    logic [7:0]  period_q;
    logic [7:0]  fall_cnt_q;
    logic [15:0] hold_cnt_q;

    logic [7:0]  p_next_d;
    logic [11:0] score_inc_d;

    // Pipe period shrinks with level but never below the floor; latched only at reload.
    always_comb begin
        p_next_d = MIN8;
        if (({5'b0, level_q} + {1'b0, MIN8}) < {1'b0, INIT8}) begin
            p_next_d = INIT8 - {4'b0, level_q};
        end
    end

    always_comb begin
        score_inc_d = score_q;
        if (score_q != 12'h999) begin
            if (score_q[3:0] != 4'd9) begin
                score_inc_d[3:0] = score_q[3:0] + 4'd1;
            end else begin
                score_inc_d[3:0] = 4'd0;
                if (score_q[7:4] != 4'd9) begin
                    score_inc_d[7:4] = score_q[7:4] + 4'd1;
                end else begin
                    score_inc_d[7:4]  = 4'd0;
                    score_inc_d[11:8] = score_q[11:8] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            active_q    <= 1'b0;
            game_over_q <= 1'b0;
            pipe_tick_q <= 1'b0;
            fall_tick_q <= 1'b0;
            score_q     <= '0;
            best_q      <= '0;
            level_q     <= '0;
            pt_cnt_q    <= '0;
            pipe_cnt_q  <= '0;
            period_q    <= '0;
            fall_cnt_q  <= '0;
            hold_cnt_q  <= '0;
        end else begin
            pipe_tick_q <= 1'b0;
            fall_tick_q <= 1'b0;
            case (state_q)
                S_IDLE, S_OVER_WAIT: begin
                    if (press) begin
                        state_q     <= S_PLAY;
                        active_q    <= 1'b1;
                        game_over_q <= 1'b0;
                        score_q     <= '0;
                        level_q     <= '0;
                        pt_cnt_q    <= '0;
                        pipe_cnt_q  <= '0;
                        fall_cnt_q  <= '0;
                        period_q    <= INIT8;
                    end
                end
                S_PLAY: begin
                    if (crash) begin
                        state_q     <= S_OVER_HOLD;
                        active_q    <= 1'b0;
                        game_over_q <= 1'b1;
                        hold_cnt_q  <= '0;
                        // Packed BCD digits order the same as plain binary.
                        if (score_q > best_q) begin
                            best_q <= score_q;
                        end
                    end else begin
                        if (pipe_cnt_q == period_q - 8'd1) begin
                            pipe_tick_q <= 1'b1;
                            pipe_cnt_q  <= '0;
                            period_q    <= p_next_d;
                        end else begin
                            pipe_cnt_q <= pipe_cnt_q + 8'd1;
                        end

                        if (press) begin
                            fall_cnt_q <= '0;
                        end else if (fall_cnt_q == FALL_M1) begin
                            fall_tick_q <= 1'b1;
                            fall_cnt_q  <= '0;
                        end else begin
                            fall_cnt_q <= fall_cnt_q + 8'd1;
                        end

                        if (point) begin
                            score_q <= score_inc_d;
                            if (pt_cnt_q == PPL_M1) begin
                                pt_cnt_q <= '0;
                                if (level_q != 4'd15) begin
                                    level_q <= level_q + 4'd1;
                                end
                            end else begin
                                pt_cnt_q <= pt_cnt_q + 8'd1;
                            end
                        end
                    end
                end
                S_OVER_HOLD: begin
                    if (hold_cnt_q == HOLD_M1) begin
                        state_q    <= S_OVER_WAIT;
                        hold_cnt_q <= '0;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 16'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign active    = active_q;
    assign game_over = game_over_q;
    assign pipe_tick = pipe_tick_q;
    assign fall_tick = fall_tick_q;
    assign flap      = press & (state_q == S_PLAY);
    assign score     = score_q;
    assign best      = best_q;
    assign level     = level_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with default parameters; expected values hand-derived.
module tb_game_sequencer;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        press = 1'b0;
    logic        crash = 1'b0;
    logic        point = 1'b0;
    logic        active, game_over, pipe_tick, fall_tick, flap;
    logic [11:0] score, best;
    logic [3:0]  level;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic        found;

    game_sequencer #(
        .PIPE_PERIOD_INIT(8),
        .PIPE_PERIOD_MIN (3),
        .FALL_PERIOD     (4),
        .POINTS_PER_LEVEL(5),
        .OVER_HOLD       (64)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .press    (press),
        .crash    (crash),
        .point    (point),
        .active   (active),
        .game_over(game_over),
        .pipe_tick(pipe_tick),
        .fall_tick(fall_tick),
        .flap     (flap),
        .score    (score),
        .best     (best),
        .level    (level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #2 reset = 1'b0;
        #10;
        chk("rst_active", active, 0);
        chk("rst_over", game_over, 0);
        chk("rst_pipe", pipe_tick, 0);
        chk("rst_fall", fall_tick, 0);
        chk("rst_score", score, 0);
        chk("rst_best", best, 0);
        chk("rst_level", level, 0);
        @(negedge clk);
        reset = 1'b1;
        step();
        chk("idle_active", active, 0);
        crash = 1'b1;
        step();
        crash = 1'b0;
        chk("idle_crash", game_over, 0);

        // Game 1: tick cadence from entry
        press = 1'b1;
        #1 chk("flap_idle", flap, 0);
        step();
        press = 1'b0;
        chk("start_active", active, 1);
        chk("start_score", score, 0);
        for (int k = 1; k <= 24; k++) begin
            step();
            chk($sformatf("pipe_e%0d", k), pipe_tick, (k % 8 == 0));
            chk($sformatf("fall_e%0d", k), fall_tick, (k % 4 == 0));
        end
        step();
        chk("fall_e25", fall_tick, 0);
        press = 1'b1;
        #1 chk("flap_play", flap, 1);
        step();
        press = 1'b0;
        chk("fall_e26", fall_tick, 0);
        step();
        step();
        chk("fall_supp_e28", fall_tick, 0);
        step();
        step();
        chk("fall_after_press", fall_tick, 1);
        chk("pipe_e30", pipe_tick, 0);
        step();
        step();
        chk("pipe_e32", pipe_tick, 1);

        point = 1'b1;
        repeat (3) step();
        point = 1'b0;
        chk("score3", score, 12'h003);

        // point and crash together: crash wins
        point = 1'b1;
        crash = 1'b1;
        step();
        point = 1'b0;
        crash = 1'b0;
        chk("crash_score", score, 12'h003);
        chk("crash_best", best, 12'h003);
        chk("crash_over", game_over, 1);
        chk("crash_active", active, 0);
        chk("crash_pipe", pipe_tick, 0);
        chk("crash_fall", fall_tick, 0);
        repeat (9) step();
        press = 1'b1;
        step();
        press = 1'b0;
        chk("hold10_active", active, 0);
        chk("hold10_over", game_over, 1);
        repeat (53) step();
        chk("hold63_fall", fall_tick, 0);
        press = 1'b1;
        step();
        press = 1'b0;
        chk("hold64_active", active, 0);
        chk("hold64_over", game_over, 1);
        press = 1'b1;
        step();
        press = 1'b0;
        chk("restart_active", active, 1);
        chk("restart_over", game_over, 0);
        chk("restart_score", score, 0);
        chk("restart_best", best, 12'h003);

        // Game 2: level 1 after 5 points, period 7 from the reload at e8
        point = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
        end
        point = 1'b0;
        chk("score5", score, 12'h005);
        chk("level1", level, 1);
        for (int k = 6; k <= 22; k++) begin
            step();
            chk($sformatf("g2_pipe_e%0d", k), pipe_tick, (k == 8 || k == 15 || k == 22));
        end

        point = 1'b1;
        repeat (1000) step();
        point = 1'b0;
        chk("sat_score", score, 12'h999);
        chk("sat_level", level, 15);
        point = 1'b1;
        step();
        point = 1'b0;
        chk("sat_score_more", score, 12'h999);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (pipe_tick) found = 1'b1;
        end
        chk("p3_found", found, 1);
        step();
        chk("p3_plus1", pipe_tick, 0);
        step();
        chk("p3_plus2", pipe_tick, 0);
        step();
        chk("p3_plus3", pipe_tick, 1);

        crash = 1'b1;
        step();
        crash = 1'b0;
        chk("best999", best, 12'h999);
        repeat (64) step();
        press = 1'b1;
        step();
        press = 1'b0;
        chk("g3_active", active, 1);
        chk("g3_level", level, 0);
        crash = 1'b1;
        step();
        crash = 1'b0;
        chk("best_keep", best, 12'h999);
        repeat (64) step();
        press = 1'b1;
        step();
        press = 1'b0;
        point = 1'b1;
        repeat (7) step();
        point = 1'b0;
        chk("score7", score, 12'h007);

        // Asynchronous reset mid-game
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_active", active, 0);
        chk("mid_rst_score", score, 0);
        chk("mid_rst_best", best, 0);
        chk("mid_rst_level", level, 0);
        chk("mid_rst_over", game_over, 0);
        @(negedge clk);
        step();
        reset = 1'b1;
        step();
        chk("post_rst_active", active, 0);
        chk("post_rst_pipe", pipe_tick, 0);
        press = 1'b1;
        step();
        press = 1'b0;
        chk("post_rst_play", active, 1);
        chk("post_rst_best", best, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
